wb_stage_mlane: RTL
===================

# wb_stage_mlane

Parametrised multi-lane successor of the single-lane writeback stage. It accepts up to LANES retiring instructions per cycle from the memory stage and commits their register writes in one cycle. It also drives the forwarding buses toward execute. Retirements are serialised in program order through a debug FIFO onto the single-lane debug trace port. Flow control is a valid/allowin handshake instead of the stall vector.

## Interface
- LANES, 2, retire lanes per cycle, 1..4; lane 0 is oldest
- MS_LANE_WD, 102, per-lane bus width {reg_we, dest[4:0], result[31:0], pc[31:0], inst[31:0]}, MSB first
- WS_TO_RF_BUS_WD, 38, per-lane write bus {we, dest[4:0], wdata[31:0]}
- DBG_DEPTH, 4, debug FIFO entries, power of two, >= LANES
- clk  in  1  single clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- flush  in  1  discard held group (exception/ertn redirect)
- ms_to_ws_valid  in  1  memory stage offers a group
- ms_to_ws_lane_valid  in  LANES  per-lane valid, contiguous from bit 0
- ms_to_ws_bus  in  LANES*MS_LANE_WD  lane i at [i*MS_LANE_WD +: MS_LANE_WD]
- ws_allowin  out  1  stage accepts a group this cycle
- ws_to_rf_bus  out  LANES*WS_TO_RF_BUS_WD  register-file write ports
- ws_to_es_bus  out  LANES*WS_TO_RF_BUS_WD  forwarding to execute
- debug_wb_pc  out  32; debug_wb_rf_we  out  4; debug_wb_rf_wnum  out  5; debug_wb_rf_wdata  out  32

## Operation
- State: ws_valid, captured lane_valid and bus registers, debug FIFO with wr_ptr, rd_ptr and count. count is $clog2(DBG_DEPTH+1) bits wide. Pointers wrap modulo DBG_DEPTH.
- n_valid = popcount of the captured lane_valid.
- ws_ready_go = ws_valid && !flush && (DBG_DEPTH - count >= n_valid).
- Free-space check uses the registered count only. There is no credit for a same-cycle pop.
- ws_allowin = !ws_valid || ws_ready_go.
- Capture: on ms_to_ws_valid && ws_allowin && !flush, load bus and lane_valid and set ws_valid.
- If ws_ready_go and no new capture occurs, clear ws_valid.
- Commit cycle (ws_ready_go=1):
  - Lane i RF we = lane_valid[i] && reg_we[i].
  - If a younger valid lane writes the same dest, the older lane's we is forced to 0.
  - dest==0 writes are passed through; the register file ignores r0.
- When ws_ready_go=0, all RF we bits are 0.
- ws_to_es_bus: same fields and same-dest masking as the RF bus, gated by ws_valid && !flush only. Forwarding stays valid while the group waits for FIFO space.
- Debug FIFO push: on the commit edge, push the n_valid lanes in lane order, lane 0 at wr_ptr, including lanes with reg_we=0.
- Debug FIFO pop: when count!=0, one entry per cycle.
- Debug outputs show the head entry: pc, {4{we}}, wnum, wdata. When empty, all are 0.
- On a same-cycle push and pop: count_next = count + n_valid - 1.
- flush:
  - Clears ws_valid at the next edge and blocks capture that cycle.
  - Suppresses RF writes and forwarding.
  - Does not purge the debug FIFO; already-committed entries drain normally.
- Reset (resetn=0, asynchronous): ws_valid=0, lane_valid=0, pointers=0, count=0. All outputs then read 0, and ws_allowin=1.
- Reset released mid-drain: FIFO contents are lost. No partial entries are emitted.

## Timing
- Capture at edge E. Commit combinationally during cycle E+1 if space exists, so RF writes at edge E+1. Stage latency is 1 cycle.
- Lane 0 appears on the debug port in cycle E+2 and lane k in cycle E+2+k, assuming an empty FIFO beforehand.
- Back-to-back two-lane groups with DBG_DEPTH=4 saturate. Sustained throughput is bounded by one debug retirement per cycle, and ws_allowin drops when free space < n_valid.
- Full FIFO (count=DBG_DEPTH) with ws_valid: ws_allowin=0.
- After one pop, a one-lane group commits the next cycle.
- flush and capture in the same cycle: flush wins.

## Test plan
- Reset then ms_to_ws_valid=1, lane_valid=2'b11, lane0 {we=1, r5, 0x11, pc 0x1c000000}, lane1 {we=1, r6, 0x22, pc 0x1c000004} -> RF writes r5=0x11 and r6=0x22 at the same edge. The debug port shows pc 0x1c000000 then 0x1c000004 on consecutive cycles, then zeros.
- Both lanes write r7 (0xAA lane0, 0xBB lane1) -> only lane1 RF we=1. Debug shows both entries in order, each with we=4'hf.
- Offer continuous two-lane groups for 10 cycles with DBG_DEPTH=4 -> ws_allowin deasserts whenever free < 2. The debug pc sequence is strictly increasing by 4 with no gaps or duplicates. count never exceeds 4.
- Held group blocked by a full FIFO, then assert flush for one cycle -> no RF write for the held group. Queued debug entries still drain. The next group is accepted the cycle after flush.
- Assert resetn=0 asynchronously mid-drain with count=3 -> debug outputs and ws_to_rf_bus read 0 immediately, and ws_allowin=1.
- LANES=1 build: a single-lane stream of 5 instructions -> one RF write per cycle. Debug output lags the RF write by 1 cycle.

Source files
------------

// File: rtl/wb_stage_mlane.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_mlane
// Brief    : multi-lane writeback stage, RF/forwarding buses, in-order debug FIFO
// Revision : 1.0
// ============================================================================
module wb_stage_mlane #(
   parameter int LANES           = 2,
   parameter int MS_LANE_WD      = 102,
   parameter int WS_TO_RF_BUS_WD = 38,
   parameter int DBG_DEPTH       = 4
) (
   input  logic                               clk,
   input  logic                               resetn,
   input  logic                               flush,
   input  logic                               ms_to_ws_valid,
   input  logic [LANES-1:0]                   ms_to_ws_lane_valid,
   input  logic [LANES*MS_LANE_WD-1:0]        ms_to_ws_bus,
   output logic                               ws_allowin,
   output logic [LANES*WS_TO_RF_BUS_WD-1:0]   ws_to_rf_bus,
   output logic [LANES*WS_TO_RF_BUS_WD-1:0]   ws_to_es_bus,
   output logic [31:0]                        debug_wb_pc,
   output logic [3:0]                         debug_wb_rf_we,
   output logic [4:0]                         debug_wb_rf_wnum,
   output logic [31:0]                        debug_wb_rf_wdata
);
   localparam int C_PTR_W = (DBG_DEPTH > 1) ? $clog2(DBG_DEPTH) : 1;
   localparam int C_CNT_W = $clog2(DBG_DEPTH + 1);
   localparam int C_ENT_W = 70;  // {pc[31:0], we, wnum[4:0], wdata[31:0]}

   logic                          ws_valid_q, ws_valid_d;
   logic [LANES-1:0]              lane_valid_q, lane_valid_d;
   logic [LANES*MS_LANE_WD-1:0]   bus_q, bus_d;
   logic [C_PTR_W-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [C_CNT_W-1:0]            count_q, count_d;
   logic [C_ENT_W-1:0]            fifo_q [DBG_DEPTH];

   logic [C_CNT_W-1:0]            w_n_valid;
   logic                          w_ready_go, w_capture, w_pop;
   logic [LANES-1:0]              w_reg_we, w_lane_wr, w_lane_we;
   logic [4:0]                    w_dest   [LANES];
   logic [31:0]                   w_result [LANES];
   logic [31:0]                   w_pc     [LANES];
   logic [C_PTR_W-1:0]            w_wr_idx [LANES];
   logic [C_ENT_W-1:0]            w_head;
   logic                          w_unused_inst;

   always_comb begin
      w_n_valid     = '0;
      w_unused_inst = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         w_reg_we[i]   = bus_q[i*MS_LANE_WD + 101];
         w_dest[i]     = bus_q[i*MS_LANE_WD + 96 +: 5];
         w_result[i]   = bus_q[i*MS_LANE_WD + 64 +: 32];
         w_pc[i]       = bus_q[i*MS_LANE_WD + 32 +: 32];
         w_unused_inst = w_unused_inst ^ (^bus_q[i*MS_LANE_WD +: 32]);
         w_lane_wr[i]  = lane_valid_q[i] && w_reg_we[i];
         w_n_valid     = w_n_valid + C_CNT_W'(lane_valid_q[i]);
         w_wr_idx[i]   = C_PTR_W'((32'(wr_ptr_q) + 32'(i)) % DBG_DEPTH);
      end
   end

   // An older lane loses its write when a younger valid lane targets the same register.
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         w_lane_we[i] = w_lane_wr[i];
         for (int j = i + 1; j < LANES; j++) begin
            if (w_lane_wr[j] && (w_dest[j] == w_dest[i])) begin
               w_lane_we[i] = 1'b0;
            end
         end
      end
   end

   assign w_ready_go = ws_valid_q && !flush &&
                       ((32'(count_q) + 32'(w_n_valid)) <= 32'(DBG_DEPTH));
   assign ws_allowin = !ws_valid_q || w_ready_go;
   assign w_capture  = ms_to_ws_valid && ws_allowin && !flush;
   assign w_pop      = (count_q != '0);

   always_comb begin
      ws_to_rf_bus = '0;
      ws_to_es_bus = '0;
      for (int i = 0; i < LANES; i++) begin
         if (w_ready_go) begin
            ws_to_rf_bus[i*WS_TO_RF_BUS_WD +: WS_TO_RF_BUS_WD] = {w_lane_we[i], w_dest[i], w_result[i]};
         end
         if (ws_valid_q && !flush) begin
            ws_to_es_bus[i*WS_TO_RF_BUS_WD +: WS_TO_RF_BUS_WD] = {w_lane_we[i], w_dest[i], w_result[i]};
         end
      end
   end

   always_comb begin
      ws_valid_d   = ws_valid_q;
      lane_valid_d = lane_valid_q;
      bus_d        = bus_q;
      if (w_capture) begin
         ws_valid_d   = 1'b1;
         lane_valid_d = ms_to_ws_lane_valid;
         bus_d        = ms_to_ws_bus;
      end else if (flush || w_ready_go) begin
         ws_valid_d   = 1'b0;
      end
      wr_ptr_d = w_ready_go ? C_PTR_W'((32'(wr_ptr_q) + 32'(w_n_valid)) % DBG_DEPTH) : wr_ptr_q;
      rd_ptr_d = w_pop ? C_PTR_W'((32'(rd_ptr_q) + 32'd1) % DBG_DEPTH) : rd_ptr_q;
      count_d  = count_q + (w_ready_go ? w_n_valid : '0) - C_CNT_W'(w_pop);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ws_valid_q   <= 1'b0;
         lane_valid_q <= '0;
         bus_q        <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         ws_valid_q   <= ws_valid_d;
         lane_valid_q <= lane_valid_d;
         bus_q        <= bus_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
      end
   end

   // Every valid lane is traced, including those that do not write the RF.
   always_ff @(posedge clk) begin
      if (w_ready_go) begin
         for (int i = 0; i < LANES; i++) begin
            if (lane_valid_q[i]) begin
               fifo_q[w_wr_idx[i]] <= {w_pc[i], w_reg_we[i], w_dest[i], w_result[i]};
            end
         end
      end
   end

   always_comb begin
      w_head            = fifo_q[rd_ptr_q];
      debug_wb_pc       = '0;
      debug_wb_rf_we    = '0;
      debug_wb_rf_wnum  = '0;
      debug_wb_rf_wdata = '0;
      if (w_pop) begin
         debug_wb_pc       = w_head[69:38];
         debug_wb_rf_we    = {4{w_head[37]}};
         debug_wb_rf_wnum  = w_head[36:32];
         debug_wb_rf_wdata = w_head[31:0];
      end
   end
endmodule
`default_nettype wire
